// File: rtl/cache_fill_responder.sv
// cache_fill_responder
//
// Memory-side responder for the data cache's line-fill path. A request
// carries the missing word address. After a fixed access latency, the four
// words of that line are read from an internal word-addressed backing store,
// one word per cycle. They are then presented together on
// miss_data1..miss_data4 with a one-cycle fill_valid strobe. A preload write
// port initialises the backing store.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   req_valid, req_addr  line-fill request (req_addr[1:0] ignored)
//   req_ready            high while idle; a request is accepted on that edge
//   fill_valid           one-cycle strobe: miss_data1..4 hold the line
//   miss_data1..4        words at offsets 0..3 of the requested line
//   busy                 high whenever a fill is in progress
//   wr_en, wr_addr, wr_data  preload write port, accepted in every state
module cache_fill_responder #(
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              fill_valid,
   output logic [DATA_W-1:0] miss_data1,
   output logic [DATA_W-1:0] miss_data2,
   output logic [DATA_W-1:0] miss_data3,
   output logic [DATA_W-1:0] miss_data4,
   output logic              busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

   localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

   state_t              state;
   logic [ADDR_W-3:0]   line;
   logic [3:0]          lat_cnt;
   logic [1:0]          beat;
   logic [DATA_W-1:0]   mem [2**ADDR_W];
   logic [DATA_W-1:0]   rd_word;
   logic                unused_offset;

   // The word offset of the request never matters: a fill always returns the
   // whole line starting at offset 0.
   assign unused_offset = ^req_addr[1:0];

   assign req_ready = (state == IDLE);
   assign busy      = ~req_ready;

   // Backing store has no reset, so its contents survive an aborted fill.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // The read sees the store before any write on the same edge. A write to
   // a later beat of the current line is therefore picked up by this burst.
   assign rd_word = mem[{line, beat}];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         line       <= '0;
         lat_cnt    <= '0;
         beat       <= '0;
         fill_valid <= 1'b0;
         miss_data1 <= '0;
         miss_data2 <= '0;
         miss_data3 <= '0;
         miss_data4 <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  line    <= req_addr[ADDR_W-1:2];
                  lat_cnt <= LAT_INIT;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt == 4'd0) begin
                  beat  <= 2'd0;
                  state <= BURST;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            BURST: begin
               case (beat)
                  2'd0:    miss_data1 <= rd_word;
                  2'd1:    miss_data2 <= rd_word;
                  2'd2:    miss_data3 <= rd_word;
                  default: miss_data4 <= rd_word;
               endcase
               // The beat counter wraps back to 0. The line address is never
               // incremented, so the top line does not run into line 0.
               beat <= beat + 2'd1;
               if (beat == 2'd3) begin
                  fill_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               // DONE does not accept a request. The next acceptance is one
               // edge after the return to IDLE.
               fill_valid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_fill_responder.sv
module tb_cache_fill_responder;

   localparam int LAT = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [14:0] req_addr;
   logic        req_ready;
   logic        fill_valid;
   logic [31:0] miss_data1, miss_data2, miss_data3, miss_data4;
   logic        busy;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [31:0] wr_data;

   cache_fill_responder #(.ADDR_W(15), .DATA_W(32), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .fill_valid(fill_valid),
      .miss_data1(miss_data1), .miss_data2(miss_data2),
      .miss_data3(miss_data3), .miss_data4(miss_data4),
      .busy(busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: a fill accepted at edge e0 captures word k from the
   // store (as it was before that edge's write) at edge e0+LAT+1+k. It
   // strobes at e0+LAT+4 and becomes idle again after edge e0+LAT+5.
   logic [31:0] ref_mem [0:32767];
   int          cyc      = 0;
   bit          m_active = 1'b0;
   int          m_e0     = 0;
   logic [12:0] m_line   = '0;
   logic [31:0] m_words [4] = '{default: '0};
   bit          m_fill   = 1'b0;
   int          m_fills  = 0;
   int          dut_fills = 0;

   task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic check_outputs(input string nm);
      chk(nm, {req_ready, busy, fill_valid, miss_data4, miss_data3, miss_data2, miss_data1},
              {!m_active, m_active, m_fill, m_words[3], m_words[2], m_words[1], m_words[0]});
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_fill   = 1'b0;
      for (int k = 0; k < 4; k++) m_words[k] = '0;
   endtask

   task automatic model_edge();
      int e;
      e = cyc + 1;
      if (rst) begin
         model_reset();
      end else begin
         m_fill = 1'b0;
         if (m_active) begin
            for (int k = 0; k < 4; k++)
               if (e == m_e0 + LAT + 1 + k) m_words[k] = ref_mem[{m_line, 2'(k)}];
            if (e == m_e0 + LAT + 4) m_fill = 1'b1;
            if (e == m_e0 + LAT + 5) m_active = 1'b0;
         end else if (req_valid) begin
            m_active = 1'b1;
            m_e0     = e;
            m_line   = req_addr[14:2];
         end
      end
      if (wr_en) ref_mem[wr_addr] = wr_data;
      cyc = e;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      if (fill_valid) dut_fills++;
      if (m_fill) m_fills++;
      check_outputs("cycle");
   endtask

   task automatic write_word(input logic [14:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   // Issue one request from idle, wait (bounded) for the strobe, and check
   // the latency and the four words against the given constants.
   task automatic run_req(input string nm, input logic [14:0] a, input logic [3:0][31:0] exp);
      int acc;
      bit got;
      req_valid = 1'b1; req_addr = a;
      tick();
      acc = cyc;
      req_valid = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
         tick();
         if (fill_valid) got = 1'b1;
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL %s_timeout: no fill_valid within 40 cycles", nm);
      end else begin
         chk({nm, "_lat"}, 132'(cyc - acc), 132'(LAT + 4));
         chk({nm, "_data"}, {miss_data4, miss_data3, miss_data2, miss_data1}, exp);
      end
      tick();
      chk({nm, "_ready"}, {req_ready, busy}, 2'b10);
   endtask

   typedef struct {
      logic [14:0]      addr;
      logic [3:0][31:0] d;
   } vec_t;

   vec_t tbl [6];
   int   acc;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;

      // Reset state
      tick();
      tick();
      chk("reset_state", {req_ready, busy, fill_valid, miss_data1, miss_data4}, {3'b100, 64'h0});
      rst = 1'b0;

      // Preloads
      write_word(15'h0000, 32'h11); write_word(15'h0001, 32'h22);
      write_word(15'h0002, 32'h33); write_word(15'h0003, 32'h44);
      write_word(15'h0004, 32'd10); write_word(15'h0005, 32'd12);
      write_word(15'h0006, 32'd14); write_word(15'h0007, 32'd16);
      write_word(15'h7FFC, 32'hAAAA0001); write_word(15'h7FFD, 32'hBBBB0002);
      write_word(15'h7FFE, 32'hCCCC0003); write_word(15'h7FFF, 32'hDDDD0004);

      tbl[0] = '{15'h0005, {32'd16, 32'd14, 32'd12, 32'd10}};
      tbl[1] = '{15'h0004, {32'd16, 32'd14, 32'd12, 32'd10}};
      tbl[2] = '{15'h0006, {32'd16, 32'd14, 32'd12, 32'd10}};
      tbl[3] = '{15'h0007, {32'd16, 32'd14, 32'd12, 32'd10}};
      tbl[4] = '{15'h7FFF, {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}};
      tbl[5] = '{15'h0000, {32'h44, 32'h33, 32'h22, 32'h11}};
      for (int i = 0; i < 6; i++) run_req($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].d);

      // Held request: ignored while busy, one strobe per fill
      dut_fills = 0; m_fills = 0;
      req_valid = 1'b1; req_addr = 15'h0000;
      for (int i = 0; i < 20; i++) tick();
      req_addr = 15'h0004;
      for (int i = 0; i < 20; i++) tick();
      req_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      chk("hold_fill_count", 132'(dut_fills), 132'(m_fills));
      chk("hold_fill_nonzero", 132'(dut_fills >= 3), 132'(1));

      // Reset in the 2nd BURST cycle: outputs clear at once, no strobe
      req_valid = 1'b1; req_addr = 15'h7FFF;
      tick();
      acc = cyc;
      req_valid = 1'b0;
      for (int t = 0; t < 20 && cyc < acc + LAT + 1; t++) tick();
      chk("pre_rst_word0", 132'(miss_data1), 132'(32'hAAAA0001));
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("rst_async");
      chk("rst_async_zero", {req_ready, busy, fill_valid, miss_data1}, {3'b100, 32'h0});
      tick();
      rst = 1'b0;
      dut_fills = 0;
      for (int i = 0; i < 12; i++) tick();
      chk("rst_no_fill", 132'(dut_fills), 132'(0));
      run_req("after_rst", 15'h7FFE, {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});

      // Write during burst: offset 0 at its own capture edge, offset 3 one
      // edge later (still ahead of its read)
      req_valid = 1'b1; req_addr = 15'h0004;
      tick();
      acc = cyc;
      req_valid = 1'b0;
      for (int t = 0; t < 20 && cyc < acc + LAT; t++) tick();
      write_word(15'h0004, 32'h55);
      write_word(15'h0007, 32'h77);
      for (int t = 0; t < 20 && !fill_valid; t++) tick();
      chk("wdb_fill", 132'(fill_valid), 132'(1));
      chk("wdb_old_word0", 132'(miss_data1), 132'(32'd10));
      chk("wdb_new_word3", 132'(miss_data4), 132'(32'h77));
      tick();

      // Randomized traffic against the model
      for (int a = 8; a < 32; a++) write_word(15'(a), $urandom);
      for (int i = 0; i < 600; i++) begin
         logic [12:0] ln;
         ln = ($urandom_range(0, 8) == 8) ? 13'h1FFF : 13'($urandom_range(0, 7));
         req_valid = ($urandom_range(0, 2) == 0);
         req_addr  = {ln, 2'($urandom_range(0, 3))};
         ln = ($urandom_range(0, 8) == 8) ? 13'h1FFF : 13'($urandom_range(0, 7));
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = {ln, 2'($urandom_range(0, 3))};
         wr_data = $urandom;
         tick();
      end
      req_valid = 1'b0; wr_en = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
